// File: rtl/shiftin_rx_pkg.sv
// Shared definitions for the 3-wire serial receive link (ser/sclk/lclk).
// Holds the default word length, the default synchroniser depth and the
// receive FSM state encodings.
package shiftin_rx_pkg;

  localparam int SHIFT_IF_WIDTH      = 16;
  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_OVERRUN = 2'd2
  } state_e;

endpackage

// File: rtl/shiftin_rx_sync_edge.sv
// Synchroniser chain plus rising-edge detector for one asynchronous line.
// The edge strobe is high for one clk_i cycle after the synchronised level
// goes from 0 to 1.
module shiftin_rx_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic d_i,
  output logic rise_o
);

  logic [STAGES-1:0] chain_q, chain_d;
  logic              prev_q, prev_d;

  // Next state: shift the raw line into the chain, remember the last synced level.
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d_i};
    prev_d  = chain_q[STAGES-1];
  end

  // Synchroniser and history flops.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign rise_o = chain_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/shiftin_rx.sv
// Receive end of the serial DAC link. ser_i is shifted in MSB first on each
// synchronised sclk rise; an lclk rise copies the shift register to data_o
// and pulses data_rdy_o for one cycle.
// Optional feature macro: SHIFTIN_RX_FRAME_CHECK_EN -- when defined,
// frame_err_o pulses with data_rdy_o if the frame did not hold exactly
// WIDTH bits; otherwise frame_err_o is tied low.
module shiftin_rx
  import shiftin_rx_pkg::*;
#(
  parameter int WIDTH       = SHIFT_IF_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             ser_i,
  input  logic             sclk_i,
  input  logic             lclk_i,
  output logic [WIDTH-1:0] data_o,
  output logic             data_rdy_o,
  output logic             frame_err_o
);

  // Counter reaches WIDTH+1 at most (saturates in OVERRUN).
  localparam int               CNT_W    = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic                   sclk_rise, lclk_rise;
  logic [SYNC_STAGES-1:0] ser_sync_q, ser_sync_d;
  logic                   ser_sync;

  logic [WIDTH-1:0] shreg_q, shreg_d, shreg_shift;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_shift;
  state_e           state_q, state_d, state_shift;
  logic [WIDTH-1:0] data_q, data_d;
  logic             data_rdy_q, data_rdy_d;

  shiftin_rx_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .d_i      (sclk_i),
    .rise_o   (sclk_rise)
  );

  shiftin_rx_sync_edge #(.STAGES(SYNC_STAGES)) u_lclk_sync (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .d_i      (lclk_i),
    .rise_o   (lclk_rise)
  );

  // Data line uses the same depth as sclk so the sampled bit lines up with its edge.
  always_comb begin
    ser_sync_d = {ser_sync_q[SYNC_STAGES-2:0], ser_i};
  end
  assign ser_sync = ser_sync_q[SYNC_STAGES-1];

  // Shift step first, so a latch in the same cycle sees the new bit and its count.
  always_comb begin
    shreg_shift = shreg_q;
    cnt_shift   = cnt_q;
    state_shift = state_q;
    if (sclk_rise) begin
      shreg_shift = {shreg_q[WIDTH-2:0], ser_sync};
      case (state_q)
        ST_IDLE: begin
          cnt_shift   = cnt_q + CNT_ONE;
          state_shift = ST_SHIFT;
        end
        ST_SHIFT: begin
          cnt_shift = cnt_q + CNT_ONE;
          if (cnt_q == CNT_FULL) begin
            state_shift = ST_OVERRUN;
          end
        end
        ST_OVERRUN: begin
          cnt_shift   = cnt_q;
          state_shift = ST_OVERRUN;
        end
        default: begin
          cnt_shift   = cnt_q;
          state_shift = ST_IDLE;
        end
      endcase
    end
  end

`ifdef SHIFTIN_RX_FRAME_CHECK_EN
  logic frame_err_q, frame_err_d;
`endif

  // Latch step: transfer the word, clear the count, shift register is kept.
  always_comb begin
    shreg_d    = shreg_shift;
    cnt_d      = cnt_shift;
    state_d    = state_shift;
    data_d     = data_q;
    data_rdy_d = 1'b0;
`ifdef SHIFTIN_RX_FRAME_CHECK_EN
    frame_err_d = 1'b0;
`endif
    if (lclk_rise) begin
      data_d     = shreg_shift;
      data_rdy_d = 1'b1;
      cnt_d      = '0;
      state_d    = ST_IDLE;
`ifdef SHIFTIN_RX_FRAME_CHECK_EN
      frame_err_d = (cnt_shift != CNT_FULL);
`endif
    end
  end

  // FSM, datapath and registered outputs.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ser_sync_q <= '0;
      shreg_q    <= '0;
      cnt_q      <= '0;
      state_q    <= ST_IDLE;
      data_q     <= '0;
      data_rdy_q <= 1'b0;
`ifdef SHIFTIN_RX_FRAME_CHECK_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      ser_sync_q <= ser_sync_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      data_q     <= data_d;
      data_rdy_q <= data_rdy_d;
`ifdef SHIFTIN_RX_FRAME_CHECK_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

  assign data_o     = data_q;
  assign data_rdy_o = data_rdy_q;
`ifdef SHIFTIN_RX_FRAME_CHECK_EN
  assign frame_err_o = frame_err_q;
`else
  assign frame_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_shiftin_rx.sv
// Directed bench for shiftin_rx: loopback-style frames, back-to-back frames,
// under/overrun/empty frames, reset mid-frame and coincident sclk/lclk.
module tb_shiftin_rx;

`ifdef SHIFTIN_RX_FRAME_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int PH = 3; // SYNC_STAGES+1 cycles per clock phase

  logic        clk;
  logic        reset_ni;
  logic        ser_i, sclk_i, lclk_i;
  logic [15:0] data_o;
  logic        data_rdy_o, frame_err_o;

  int checks = 0;
  int errors = 0;
  int rdy_cnt = 0;
  int err_cnt = 0;
  int stray_err = 0;

  shiftin_rx dut (
    .clk_i       (clk),
    .reset_ni    (reset_ni),
    .ser_i       (ser_i),
    .sclk_i      (sclk_i),
    .lclk_i      (lclk_i),
    .data_o      (data_o),
    .data_rdy_o  (data_rdy_o),
    .frame_err_o (frame_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (data_rdy_o) rdy_cnt++;
    if (frame_err_o) begin
      err_cnt++;
      if (!data_rdy_o) stray_err++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ser_i = b;
    wait_neg(PH);
    sclk_i = 1'b1;
    wait_neg(PH);
    sclk_i = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) send_bit(w[i]);
    wait_neg(PH);
  endtask

  task automatic latch();
    lclk_i = 1'b1;
    wait_neg(PH);
    lclk_i = 1'b0;
    wait_neg(PH + 1);
  endtask

  task automatic check_frame(input string tag, input logic [15:0] exp_data, input logic exp_err,
                             input int base_rdy, input int base_err);
    check({tag, "/pulses"}, rdy_cnt - base_rdy, 1);
    check({tag, "/data"}, data_o, exp_data);
    check({tag, "/err"}, err_cnt - base_err, exp_err ? 1 : 0);
  endtask

  initial begin
    int br, be, n;
    logic [15:0] pat;

    reset_ni = 1'b0;
    ser_i = 1'b0;
    sclk_i = 1'b0;
    lclk_i = 1'b0;
    wait_neg(3);
    check("reset/data", data_o, 16'h0000);
    check("reset/rdy", data_rdy_o, 1'b0);
    check("reset/err", frame_err_o, 1'b0);
    reset_ni = 1'b1;
    wait_neg(3);

    // 1: full frame 0x2ABC with latency measurement
    br = rdy_cnt; be = err_cnt;
    send_word(16'h2ABC, 16);
    lclk_i = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (data_rdy_o) break;
    end
    check("t1/latency", n, 3);
    wait_neg(PH);
    lclk_i = 1'b0;
    wait_neg(PH + 1);
    check_frame("t1", 16'h2ABC, 1'b0, br, be);

    // 2: back-to-back frames at minimum timing
    br = rdy_cnt; be = err_cnt;
    send_word(16'hFFFF, 16);
    latch();
    check_frame("t2a", 16'hFFFF, 1'b0, br, be);
    br = rdy_cnt; be = err_cnt;
    send_word(16'h0000, 16);
    latch();
    check_frame("t2b", 16'h0000, 1'b0, br, be);

    // 3/4: underrun (15 ones), overrun (1 then 0x8001), empty frame
    br = rdy_cnt; be = err_cnt;
    send_word(16'h7FFF, 15);
    latch();
    check_frame("t3under", 16'h7FFF, CHK, br, be);
    br = rdy_cnt; be = err_cnt;
    send_bit(1'b1);
    send_word(16'h8001, 16);
    latch();
    check_frame("t3over", 16'h8001, CHK, br, be);
    br = rdy_cnt; be = err_cnt;
    latch();
    check_frame("t3empty", 16'h8001, CHK, br, be);

    // 5: reset mid-frame, then a clean frame
    pat = 16'hA5A5;
    for (int i = 15; i >= 8; i--) send_bit(pat[i]);
    br = rdy_cnt; be = err_cnt;
    reset_ni = 1'b0;
    #1;
    check("t5/data_in_reset", data_o, 16'h0000);
    check("t5/rdy_in_reset", data_rdy_o, 1'b0);
    wait_neg(4);
    reset_ni = 1'b1;
    wait_neg(6);
    check("t5/no_pulse", rdy_cnt - br, 0);
    send_word(16'h1234, 16);
    latch();
    check_frame("t5", 16'h1234, 1'b0, br, be);

    // 6: sclk and lclk rise together on the last bit of 0x0001
    br = rdy_cnt; be = err_cnt;
    pat = 16'h0001;
    for (int i = 15; i >= 1; i--) send_bit(pat[i]);
    ser_i = 1'b1;
    wait_neg(PH);
    sclk_i = 1'b1;
    lclk_i = 1'b1;
    wait_neg(PH);
    sclk_i = 1'b0;
    lclk_i = 1'b0;
    wait_neg(PH + 1);
    check_frame("t6", 16'h0001, 1'b0, br, be);

    wait_neg(10);
    check("stray_err", stray_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
